// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// bit positions, FSM encoding and frame geometry.
package uart_tx_dev_pkg;

  // Word offsets decoded from Addr[1:0]
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_TXDATA  = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;

  // STATUS bit positions; the FIFO count occupies a 5-bit field
  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 5;

  // 8N1 frame: start + 8 data + stop
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // A divisor of 0 or 1 both mean one clock per bit
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO feeding the transmitter; the head entry is read straight
// out of the storage flops so it is stable for the whole cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointer, storage and occupancy update; push and pop together keep count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, baud timing
// and serialiser, with a level interrupt when the transmitter drains.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        en_q, en_d, ie_q, ie_d, ovf_q, ovf_d, irq_q, irq_d;
  logic [15:0] divisor_q, divisor_d;
  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d, fdiv_q, fdiv_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [CW-1:0] fifo_count;
  logic [ST_COUNT_W-1:0] count_ext;
  logic [1:0]  reg_sel;
  logic        busy, baud_done, load;
  logic        unused_bits;

  assign reg_sel     = Addr[1:0];
  assign busy        = (state_q != S_IDLE);
  assign baud_done   = (baud_q == fdiv_q - 16'd1);
  assign count_ext   = ST_COUNT_W'(fifo_count);
  assign unused_bits = &{1'b0, Addr[29:2], Din[31:16]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (Din[7:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Register writes, FIFO push/overflow and next interrupt level
  always_comb begin
    en_d      = en_q;
    ie_d      = ie_q;
    ovf_d     = ovf_q;
    divisor_d = divisor_q;
    fifo_push = 1'b0;
    if (WE) begin
      case (reg_sel)
        REG_CTRL: begin
          en_d = Din[CTRL_EN_BIT];
          ie_d = Din[CTRL_IE_BIT];
        end
        REG_STATUS: ovf_d = 1'b0;
        REG_TXDATA: begin
          if (!fifo_full || fifo_pop) fifo_push = 1'b1;
          else                        ovf_d     = 1'b1;
        end
        default: divisor_d = Din[15:0];
      endcase
    end
    irq_d = ie_d && en_d && fifo_empty && !busy && !fifo_push;
  end

  // Serialiser next state: start/data/stop bit timing and frame chaining
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fdiv_d   = fdiv_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    case (state_q)
      S_IDLE: load = en_q && !fifo_empty;
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'(DATA_BITS - 1)) state_d = S_STOP;
          else                            bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          state_d = S_IDLE;
          load    = en_q && !fifo_empty;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_head;
      fdiv_d   = eff_div(divisor_q);
      baud_d   = '0;
      state_d  = S_START;
    end
  end

  // All registers of the device, returning to idle-line values on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      divisor_q <= DEFAULT_DIV;
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      fdiv_q    <= 16'd1;
    end else begin
      en_q      <= en_d;
      ie_q      <= ie_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
      divisor_q <= divisor_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      fdiv_q    <= fdiv_d;
    end
  end

  // Line level follows the current frame position; idle and stop are high
  always_comb begin
    txd = 1'b1;
    case (state_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  // Zero-latency read mux over the register map
  always_comb begin
    Dout = '0;
    case (reg_sel)
      REG_CTRL: begin
        Dout[CTRL_EN_BIT] = en_q;
        Dout[CTRL_IE_BIT] = ie_q;
      end
      REG_STATUS: begin
        Dout[ST_BUSY_BIT]  = busy;
        Dout[ST_FULL_BIT]  = fifo_full;
        Dout[ST_EMPTY_BIT] = fifo_empty;
        Dout[ST_OVF_BIT]   = ovf_q;
        Dout[ST_COUNT_LSB +: ST_COUNT_W] = count_ext;
      end
      REG_TXDATA: Dout = '0;
      default:    Dout[15:0] = divisor_q;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed self-checking bench for uart_tx_dev: register table, then
// hand-written frame sequences checked cycle by cycle against txd/BUSY/IRQ.
module tb_uart_tx_dev;

  localparam logic [1:0] A_CTRL = 2'd0, A_STATUS = 2'd1, A_TXDATA = 2'd2, A_DIV = 2'd3;

  logic        clk;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        txd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [27:0] hi;
    logic [1:0]  addr;
    logic [31:0] din;
    logic        chk;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[12];

  uart_tx_dev dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ),
    .txd   (txd)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    Addr = {v.hi, v.addr};
    Din  = v.din;
    WE   = v.we;
    #1;
    if (v.chk) checkOutput($sformatf("vec%0d dout", idx), Dout, v.exp_dout);
    checkOutput($sformatf("vec%0d txd", idx), 32'(txd), 32'd1);
    checkOutput($sformatf("vec%0d irq", idx), 32'(IRQ), 32'd0);
    @(posedge clk);
    #1 WE = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = {28'd0, a};
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1 WE = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [1:0] a, input logic [31:0] expv);
    @(negedge clk);
    Addr = {28'd0, a};
    WE   = 1'b0;
    #1 checkOutput(name, Dout, expv);
  endtask

  // One idle cycle: STATUS, line high, expected interrupt level
  task automatic idleCheck(input string name, input logic [31:0] exp_status, input logic exp_irq);
    @(negedge clk);
    Addr = {28'd0, A_STATUS};
    WE   = 1'b0;
    #1;
    checkOutput({name, " status"}, Dout, exp_status);
    checkOutput({name, " txd"}, 32'(txd), 32'd1);
    checkOutput({name, " irq"}, 32'(IRQ), 32'(exp_irq));
  endtask

  function automatic logic expTxd(input logic [7:0] b, input int div, input int k);
    if (k < div)     return 1'b0;
    if (k < 9 * div) return b[(k - div) / div];
    return 1'b1;
  endfunction

  // Checks 10*div cycles of a frame; optionally issues one write at cycle mid_k
  task automatic frameCheck(input string name, input logic [7:0] b, input int div,
                            input int mid_k, input logic [1:0] mid_a, input logic [31:0] mid_d);
    for (int k = 0; k < 10 * div; k++) begin
      @(negedge clk);
      if (k == mid_k) begin
        Addr = {28'd0, mid_a};
        Din  = mid_d;
        WE   = 1'b1;
      end else begin
        Addr = {28'd0, A_STATUS};
        WE   = 1'b0;
      end
      #1;
      checkOutput($sformatf("%s txd k=%0d", name, k), 32'(txd), 32'(expTxd(b, div, k)));
      checkOutput($sformatf("%s irq k=%0d", name, k), 32'(IRQ), 32'd0);
      if (k != mid_k) checkOutput($sformatf("%s busy k=%0d", name, k), 32'(Dout[0]), 32'd1);
    end
    @(posedge clk);
    #1 WE = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 28'h0000000, A_CTRL,   32'h0,         1'b1, 32'h0};
    vecs[1]  = '{1'b0, 28'h0000000, A_STATUS, 32'h0,         1'b1, 32'h4};
    vecs[2]  = '{1'b0, 28'h0000000, A_TXDATA, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b0, 28'h0000000, A_DIV,    32'h0,         1'b1, 32'd868};
    vecs[4]  = '{1'b1, 28'hABCDEF1, A_DIV,    32'hFFFF_0004, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 28'h1234567, A_DIV,    32'h0,         1'b1, 32'h4};
    vecs[6]  = '{1'b1, 28'h0000000, A_CTRL,   32'hFFFF_FFFE, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 28'h0000000, A_CTRL,   32'h0,         1'b1, 32'h2};
    vecs[8]  = '{1'b1, 28'h0000000, A_STATUS, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 28'h0000000, A_STATUS, 32'h0,         1'b1, 32'h4};
    vecs[10] = '{1'b1, 28'h0000000, A_CTRL,   32'h0,         1'b0, 32'h0};
    vecs[11] = '{1'b0, 28'h0000000, A_CTRL,   32'h0,         1'b1, 32'h0};

    reset = 1'b0;
    Addr  = '0;
    WE    = 1'b0;
    Din   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset txd", 32'(txd), 32'd1);
    checkOutput("reset irq", 32'(IRQ), 32'd0);
    reset = 1'b1;

    $display("[TB] register table");
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    $display("[TB] single frame 0xA5 at 4 clocks per bit");
    writeReg(A_DIV, 32'd4);
    writeReg(A_CTRL, 32'h1);
    writeReg(A_TXDATA, 32'hA5);
    idleCheck("a5 pre", 32'h10, 1'b0);
    frameCheck("a5", 8'hA5, 4, -1, A_STATUS, 32'h0);
    idleCheck("a5 post", 32'h4, 1'b0);

    $display("[TB] FIFO fill, overflow and back-to-back frames");
    writeReg(A_CTRL, 32'h0);
    writeReg(A_DIV, 32'd2);
    for (int i = 1; i <= 5; i++) writeReg(A_TXDATA, 32'(i));
    readCheck("ovf status", A_STATUS, 32'h4A);
    writeReg(A_STATUS, 32'h0);
    readCheck("ovf clear", A_STATUS, 32'h42);
    writeReg(A_CTRL, 32'h1);
    idleCheck("b2b pre", 32'h42, 1'b0);
    for (int i = 1; i <= 4; i++) frameCheck($sformatf("b2b%0d", i), 8'(i), 2, -1, A_STATUS, 32'h0);
    idleCheck("b2b post", 32'h4, 1'b0);

    $display("[TB] interrupt on drain");
    writeReg(A_CTRL, 32'h0);
    writeReg(A_DIV, 32'd1);
    writeReg(A_TXDATA, 32'h3C);
    writeReg(A_CTRL, 32'h3);
    idleCheck("irq pre", 32'h10, 1'b0);
    frameCheck("irq3c", 8'h3C, 1, -1, A_STATUS, 32'h0);
    idleCheck("irq fall", 32'h4, 1'b0);
    idleCheck("irq rise", 32'h4, 1'b1);
    writeReg(A_DIV, 32'd0);
    writeReg(A_TXDATA, 32'h81);
    idleCheck("irq wr", 32'h10, 1'b0);
    frameCheck("div0", 8'h81, 1, -1, A_STATUS, 32'h0);
    idleCheck("irq2 fall", 32'h4, 1'b0);
    idleCheck("irq2 rise", 32'h4, 1'b1);
    writeReg(A_CTRL, 32'h1);
    idleCheck("ie clear", 32'h4, 1'b0);

    $display("[TB] mid-frame divisor change and enable clear");
    writeReg(A_CTRL, 32'h0);
    writeReg(A_DIV, 32'd3);
    writeReg(A_TXDATA, 32'h96);
    writeReg(A_TXDATA, 32'h5A);
    writeReg(A_TXDATA, 32'hC3);
    writeReg(A_TXDATA, 32'h0F);
    writeReg(A_CTRL, 32'h1);
    idleCheck("mid pre", 32'h42, 1'b0);
    frameCheck("div3", 8'h96, 3, 7, A_DIV, 32'd8);
    frameCheck("div8", 8'h5A, 8, 20, A_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) idleCheck($sformatf("held%0d", i), 32'h20, 1'b0);

    $display("[TB] reset during data bit 3");
    writeReg(A_DIV, 32'd4);
    writeReg(A_CTRL, 32'h1);
    idleCheck("rst pre", 32'h20, 1'b0);
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      Addr = {28'd0, A_STATUS};
      #1 checkOutput($sformatf("c3 txd k=%0d", k), 32'(txd), 32'(expTxd(8'hC3, 4, k)));
    end
    #1 reset = 1'b0;
    #1;
    checkOutput("rst txd", 32'(txd), 32'd1);
    checkOutput("rst status", Dout, 32'h4);
    Addr = {28'd0, A_DIV};
    #1 checkOutput("rst div", Dout, 32'd868);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) idleCheck($sformatf("after rst%0d", i), 32'h4, 1'b0);
    readCheck("after rst ctrl", A_CTRL, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
